hand_centroid_tracker: RTL

Per-frame hand position extractor that consumes the filtered skin-mask pixel stream (the same stream the finger counter uses) and produces the hand centroid (x, y) and skin-pixel area once per frame. It accumulates coordinate sums while pixels stream in. At frame end it snapshots the sums and runs a sequential restoring divider. Its outputs feed servo mapping (base/shoulder tracking) and overlay logic.

---
 rtl/hand_centroid_tracker.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hand_centroid_tracker.sv
// rtl/hand_centroid_tracker.sv - per-frame skin-pixel centroid and area with a serial restoring divider
// Optional bounding-box tracking is compiled in when HAND_BBOX_EN is defined.
module hand_centroid_tracker #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int MIN_PIXELS = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_in,
   input  logic        valid_in,
   input  logic        frame_done,
   output logic [9:0]  centroid_x,
   output logic [9:0]  centroid_y,
   output logic [18:0] pixel_count,
   output logic        hand_present,
   output logic        centroid_valid,
   output logic        busy,
   output logic        frame_dropped
`ifdef HAND_BBOX_EN
   ,
   output logic [9:0]  bbox_x_min,
   output logic [9:0]  bbox_x_max,
   output logic [9:0]  bbox_y_min,
   output logic [9:0]  bbox_y_max
`endif
);

   localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
   localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t state_q, state_d;

   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [27:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [18:0] cnt_q, cnt_d;
   logic        start_q, start_d;
   logic [27:0] snap_sum_y_q, snap_sum_y_d;
   logic [18:0] snap_cnt_q, snap_cnt_d;
   logic [27:0] dvd_q, dvd_d;
   logic [18:0] dsr_q, dsr_d;
   logic [19:0] rem_q, rem_d;
   logic [27:0] quo_q, quo_d;
   logic [4:0]  step_q, step_d;
   logic [9:0]  quo_x_q, quo_x_d, quo_y_q, quo_y_d;
   logic [9:0]  cx_q, cx_d, cy_q, cy_d;
   logic [18:0] count_q, count_d;
   logic        hp_q, hp_d;
   logic        cvalid_q, cvalid_d;
   logic        dropped_q, dropped_d;

   logic        hit, busy_any, take_snap, hand_ok;
   logic        div_run, in_done, last_step;
   logic [27:0] sum_x_inc, sum_y_inc;
   logic [18:0] cnt_inc;
   logic [19:0] rem_shift, rem_next;
   logic        rem_ge;
   logic [27:0] quo_next;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state; IDLE waits one cycle after the snapshot so the divider operands settle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_q)   state_d = DIV_X;
         DIV_X:   if (last_step) state_d = DIV_Y;
         DIV_Y:   if (last_step) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy    = (state_q != IDLE);
      div_run = (state_q == DIV_X) || (state_q == DIV_Y);
      in_done = (state_q == DONE);
   end

   always_comb begin
      hit       = valid_in & pixel_in;
      busy_any  = (state_q != IDLE) || start_q;
      take_snap = frame_done && !busy_any;
      hand_ok   = (snap_cnt_q >= MIN_CNT);
      last_step = (step_q == 5'd27);

      sum_x_inc = sum_x_q + (hit ? {18'd0, x_q} : 28'd0);
      sum_y_inc = sum_y_q + (hit ? {18'd0, y_q} : 28'd0);
      cnt_inc   = cnt_q + {18'd0, hit};

      rem_shift = {rem_q[18:0], dvd_q[27]};
      rem_ge    = (rem_shift >= {1'b0, dsr_q});
      rem_next  = rem_ge ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
      quo_next  = {quo_q[26:0], rem_ge};
   end

   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      sum_x_d      = sum_x_inc;
      sum_y_d      = sum_y_inc;
      cnt_d        = cnt_inc;
      start_d      = take_snap;
      snap_sum_y_d = snap_sum_y_q;
      snap_cnt_d   = snap_cnt_q;
      dvd_d        = dvd_q;
      dsr_d        = dsr_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      step_d       = step_q;
      quo_x_d      = quo_x_q;
      quo_y_d      = quo_y_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      count_d      = count_q;
      hp_d         = hp_q;
      cvalid_d     = 1'b0;
      dropped_d    = frame_done && busy_any;

      if (frame_done) begin
         x_d     = 10'd0;
         y_d     = 10'd0;
         sum_x_d = 28'd0;
         sum_y_d = 28'd0;
         cnt_d   = 19'd0;
      end else if (valid_in) begin
         if (x_q == X_LAST) begin
            x_d = 10'd0;
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // A too-small frame still runs the full division against 1 so latency is fixed
      if (take_snap) begin
         dvd_d        = sum_x_inc;
         snap_sum_y_d = sum_y_inc;
         snap_cnt_d   = cnt_inc;
         dsr_d        = (cnt_inc < MIN_CNT) ? 19'd1 : cnt_inc;
         rem_d        = 20'd0;
         quo_d        = 28'd0;
         step_d       = 5'd0;
      end

      if (div_run) begin
         rem_d  = rem_next;
         quo_d  = quo_next;
         dvd_d  = {dvd_q[26:0], 1'b0};
         step_d = step_q + 5'd1;
         if (last_step) begin
            step_d = 5'd0;
            rem_d  = 20'd0;
            quo_d  = 28'd0;
            if (state_q == DIV_X) begin
               quo_x_d = quo_next[9:0];
               dvd_d   = snap_sum_y_q;
            end else begin
               quo_y_d = quo_next[9:0];
            end
         end
      end

      if (in_done) begin
         cvalid_d = 1'b1;
         count_d  = snap_cnt_q;
         hp_d     = hand_ok;
         if (hand_ok) begin
            cx_d = quo_x_q;
            cy_d = quo_y_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         sum_x_q      <= '0;
         sum_y_q      <= '0;
         cnt_q        <= '0;
         start_q      <= 1'b0;
         snap_sum_y_q <= '0;
         snap_cnt_q   <= '0;
         dvd_q        <= '0;
         dsr_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         step_q       <= '0;
         quo_x_q      <= '0;
         quo_y_q      <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         count_q      <= '0;
         hp_q         <= 1'b0;
         cvalid_q     <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         sum_x_q      <= sum_x_d;
         sum_y_q      <= sum_y_d;
         cnt_q        <= cnt_d;
         start_q      <= start_d;
         snap_sum_y_q <= snap_sum_y_d;
         snap_cnt_q   <= snap_cnt_d;
         dvd_q        <= dvd_d;
         dsr_q        <= dsr_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         step_q       <= step_d;
         quo_x_q      <= quo_x_d;
         quo_y_q      <= quo_y_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         count_q      <= count_d;
         hp_q         <= hp_d;
         cvalid_q     <= cvalid_d;
         dropped_q    <= dropped_d;
      end
   end

   assign centroid_x     = cx_q;
   assign centroid_y     = cy_q;
   assign pixel_count    = count_q;
   assign hand_present   = hp_q;
   assign centroid_valid = cvalid_q;
   assign frame_dropped  = dropped_q;

`ifdef HAND_BBOX_EN
   logic [9:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
   logic [9:0] by_min_q, by_min_d, by_max_q, by_max_d;
   logic [9:0] sbx_min_q, sbx_min_d, sbx_max_q, sbx_max_d;
   logic [9:0] sby_min_q, sby_min_d, sby_max_q, sby_max_d;
   logic [9:0] obx_min_q, obx_min_d, obx_max_q, obx_max_d;
   logic [9:0] oby_min_q, oby_min_d, oby_max_q, oby_max_d;
   logic [9:0] bx_min_inc, bx_max_inc, by_min_inc, by_max_inc;

   // Trackers include the pixel that arrives together with frame_done
   always_comb begin
      bx_min_inc = (hit && x_q < bx_min_q) ? x_q : bx_min_q;
      bx_max_inc = (hit && x_q > bx_max_q) ? x_q : bx_max_q;
      by_min_inc = (hit && y_q < by_min_q) ? y_q : by_min_q;
      by_max_inc = (hit && y_q > by_max_q) ? y_q : by_max_q;

      bx_min_d  = bx_min_inc;
      bx_max_d  = bx_max_inc;
      by_min_d  = by_min_inc;
      by_max_d  = by_max_inc;
      sbx_min_d = sbx_min_q;
      sbx_max_d = sbx_max_q;
      sby_min_d = sby_min_q;
      sby_max_d = sby_max_q;
      obx_min_d = obx_min_q;
      obx_max_d = obx_max_q;
      oby_min_d = oby_min_q;
      oby_max_d = oby_max_q;

      if (frame_done) begin
         bx_min_d = X_LAST;
         bx_max_d = 10'd0;
         by_min_d = Y_LAST;
         by_max_d = 10'd0;
      end
      if (take_snap) begin
         sbx_min_d = bx_min_inc;
         sbx_max_d = bx_max_inc;
         sby_min_d = by_min_inc;
         sby_max_d = by_max_inc;
      end
      if (in_done && hand_ok) begin
         obx_min_d = sbx_min_q;
         obx_max_d = sbx_max_q;
         oby_min_d = sby_min_q;
         oby_max_d = sby_max_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bx_min_q  <= X_LAST;
         bx_max_q  <= '0;
         by_min_q  <= Y_LAST;
         by_max_q  <= '0;
         sbx_min_q <= X_LAST;
         sbx_max_q <= '0;
         sby_min_q <= Y_LAST;
         sby_max_q <= '0;
         obx_min_q <= X_LAST;
         obx_max_q <= '0;
         oby_min_q <= Y_LAST;
         oby_max_q <= '0;
      end else begin
         bx_min_q  <= bx_min_d;
         bx_max_q  <= bx_max_d;
         by_min_q  <= by_min_d;
         by_max_q  <= by_max_d;
         sbx_min_q <= sbx_min_d;
         sbx_max_q <= sbx_max_d;
         sby_min_q <= sby_min_d;
         sby_max_q <= sby_max_d;
         obx_min_q <= obx_min_d;
         obx_max_q <= obx_max_d;
         oby_min_q <= oby_min_d;
         oby_max_q <= oby_max_d;
      end
   end

   assign bbox_x_min = obx_min_q;
   assign bbox_x_max = obx_max_q;
   assign bbox_y_min = oby_min_q;
   assign bbox_y_max = oby_max_q;
`endif

endmodule
